// File: rtl/writeback_unit.sv
// Writeback stage: selects the load or ALU result, commits it to an 8 x 16 register file,
// and tracks busy registers and retired commits. Define WB_BYPASS_EN for same-cycle write bypass.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int REG_AW = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic                     wb_isld,
    input  logic [DATA_W+REG_AW-1:0] rdvalmem,
    input  logic [DATA_W+REG_AW-1:0] rdvalalu,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        issue_rd,
    output logic                     issue_stall,
    input  logic [REG_AW-1:0]        rs1_addr,
    input  logic [REG_AW-1:0]        rs2_addr,
    output logic [DATA_W-1:0]        rs1_data,
    output logic [DATA_W-1:0]        rs2_data,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     wb_done,
    output logic [REG_AW-1:0]        wb_last_rd,
    output logic [DATA_W-1:0]        wb_last_data,
    output logic [15:0]              retired_count
);

    logic [DATA_W-1:0]        regs_reg [NREG];
    logic [NREG-1:0]          busy_reg;
    logic [NREG-1:0]          busy_next;
    logic [NREG-1:0]          set_vec;
    logic [NREG-1:0]          clr_vec;
    logic                     done_reg;
    logic [REG_AW-1:0]        last_rd_reg;
    logic [DATA_W-1:0]        last_data_reg;
    logic [15:0]              count_reg;

    logic [DATA_W+REG_AW-1:0] sel;
    logic [DATA_W-1:0]        wb_data;
    logic [REG_AW-1:0]        wb_rd;
    logic                     wb_nonzero;
    logic                     hit1;
    logic                     hit2;
    logic                     hit_issue;
    logic                     issue_fire;

    assign sel        = wb_isld ? rdvalmem : rdvalalu;
    assign wb_data    = sel[DATA_W+REG_AW-1:REG_AW];
    assign wb_rd      = sel[REG_AW-1:0];
    assign wb_nonzero = (wb_rd != '0);

`ifdef WB_BYPASS_EN
    assign hit1      = wb_valid && wb_nonzero && (wb_rd == rs1_addr);
    assign hit2      = wb_valid && wb_nonzero && (wb_rd == rs2_addr);
    assign hit_issue = wb_valid && wb_nonzero && (wb_rd == issue_rd);
`else
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign hit_issue = 1'b0;
`endif

    assign issue_stall = issue_valid && busy_reg[issue_rd] && !hit_issue;
    assign issue_fire  = issue_valid && !issue_stall && (issue_rd != '0);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (hit1)
            rs1_data = wb_data;
        else if (rs1_addr != '0)
            rs1_data = regs_reg[rs1_addr];
        if (hit2)
            rs2_data = wb_data;
        else if (rs2_addr != '0)
            rs2_data = regs_reg[rs2_addr];
    end

    assign rs1_busy = busy_reg[rs1_addr] && !hit1;
    assign rs2_busy = busy_reg[rs2_addr] && !hit2;

    // A new issue to a register overrides a same-edge commit clearing it.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            assign set_vec[gi] = issue_fire && (issue_rd == REG_AW'(gi));
            assign clr_vec[gi] = wb_valid && (wb_rd == REG_AW'(gi));
            if (gi == 0) begin : g_r0
                assign busy_next[gi] = 1'b0;
            end else begin : g_rn
                assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    // R0 storage exists only to keep the array regular; it is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_reg[i] <= '0;
        end else if (wb_valid && wb_nonzero) begin
            regs_reg[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_reg      <= 1'b0;
            last_rd_reg   <= '0;
            last_data_reg <= '0;
            count_reg     <= '0;
        end else begin
            done_reg <= wb_valid;
            if (wb_valid) begin
                last_rd_reg   <= wb_rd;
                last_data_reg <= wb_data;
                count_reg     <= count_reg + 16'd1;
            end
        end
    end

    assign wb_done       = done_reg;
    assign wb_last_rd    = last_rd_reg;
    assign wb_last_data  = last_data_reg;
    assign retired_count = count_reg;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit against a register-file/scoreboard reference model,
// plus directed reset, select, bypass, scoreboard, R0 and counter-wrap cases.
module tb_writeback_unit;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_isld = 1'b0;
    logic [18:0] rdvalmem = '0;
    logic [18:0] rdvalalu = '0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_rd = '0;
    logic        issue_stall;
    logic [2:0]  rs1_addr = '0;
    logic [2:0]  rs2_addr = '0;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wb_done;
    logic [2:0]  wb_last_rd;
    logic [15:0] wb_last_data;
    logic [15:0] retired_count;

    writeback_unit dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_isld(wb_isld),
        .rdvalmem(rdvalmem), .rdvalalu(rdvalalu), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .issue_stall(issue_stall), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .wb_done(wb_done),
        .wb_last_rd(wb_last_rd), .wb_last_data(wb_last_data),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_regs [8];
    bit          m_busy [8];
    bit          m_done;
    logic [2:0]  m_last_rd;
    logic [15:0] m_last_data;
    logic [15:0] m_count;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_done = 1'b0; m_last_rd = '0; m_last_data = '0; m_count = '0;
    endtask

    // One cycle: called just after negedge with inputs driven; returns at next negedge.
    task automatic step();
        logic [18:0] s;
        logic [15:0] d;
        logic [2:0]  r;
        bit h1, h2, hi, st;
        s  = wb_isld ? rdvalmem : rdvalalu;
        d  = s[18:3];
        r  = s[2:0];
        h1 = BYP && wb_valid && (r == rs1_addr) && (r != 0);
        h2 = BYP && wb_valid && (r == rs2_addr) && (r != 0);
        hi = BYP && wb_valid && (r == issue_rd) && (r != 0);
        st = issue_valid && m_busy[issue_rd] && !hi;
        #1;
        check("rs1_data", rs1_data, h1 ? d : (rs1_addr == 0 ? 16'h0 : m_regs[rs1_addr]));
        check("rs2_data", rs2_data, h2 ? d : (rs2_addr == 0 ? 16'h0 : m_regs[rs2_addr]));
        check("rs1_busy", rs1_busy, m_busy[rs1_addr] && !h1);
        check("rs2_busy", rs2_busy, m_busy[rs2_addr] && !h2);
        check("issue_stall", issue_stall, st);
        @(posedge clk);
        m_done = wb_valid;
        if (wb_valid) begin
            if (r != 0) m_regs[r] = d;
            m_busy[r]   = 1'b0;
            m_last_rd   = r;
            m_last_data = d;
            m_count     = m_count + 16'd1;
        end
        if (issue_valid && !st && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        #1;
        check("wb_done", wb_done, m_done);
        check("wb_last_rd", wb_last_rd, m_last_rd);
        check("wb_last_data", wb_last_data, m_last_data);
        check("retired_count", retired_count, m_count);
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        wb_valid    = 1'($urandom_range(0, 1));
        wb_isld     = 1'($urandom_range(0, 1));
        rdvalmem    = 19'($urandom);
        rdvalalu    = 19'($urandom);
        issue_valid = 1'($urandom_range(0, 1));
        issue_rd    = 3'($urandom);
        rs1_addr    = 3'($urandom);
        rs2_addr    = 3'($urandom);
    endtask

    task automatic idle();
        wb_valid = 1'b0; issue_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", retired_count, 16'h0);
        check("rst_done", wb_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Commit R3=0x1234, then assert reset asynchronously mid-cycle
        wb_valid = 1'b1; wb_isld = 1'b0; rdvalalu = {16'h1234, 3'd3};
        step();
        idle(); rs1_addr = 3'd3;
        #2;
        check("pre_rst_r3", rs1_data, 16'h1234);
        rst = 1'b1;
        #1;
        check("async_rst_r3", rs1_data, 16'h0);
        check("async_rst_count", retired_count, 16'h0);
        check("async_rst_done", wb_done, 1'b0);
        wb_valid = 1'b1; issue_valid = 1'b1; issue_rd = 3'd5;
        @(posedge clk); #1;
        check("rst_ignore_count", retired_count, 16'h0);
        check("rst_ignore_busy", dut.busy_reg, 8'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Load vs ALU select
        wb_valid = 1'b1; wb_isld = 1'b0; rdvalalu = {16'h2222, 3'd2};
        step();
        wb_isld = 1'b1; rdvalmem = {16'hBEEF, 3'd5}; rdvalalu = {16'h1111, 3'd2};
        step();
        idle(); rs1_addr = 3'd5; rs2_addr = 3'd2;
        #1;
        check("sel_r5", rs1_data, 16'hBEEF);
        check("sel_r2", rs2_data, 16'h2222);
        check("sel_last_rd", wb_last_rd, 3'd5);
        step();
        check("sel_done_drop", wb_done, 1'b0);

        // Bypass: R4 busy, commit 0x00AA to R4 while reading it
        issue_valid = 1'b1; issue_rd = 3'd4;
        step();
        idle(); wb_valid = 1'b1; wb_isld = 1'b0; rdvalalu = {16'h00AA, 3'd4}; rs1_addr = 3'd4;
        #1;
        check("byp_data", rs1_data, BYP ? 16'h00AA : 16'h0000);
        check("byp_busy", rs1_busy, BYP ? 1'b0 : 1'b1);
        step();

        // Scoreboard: issue 6 then second issue to 6 stalls
        idle(); issue_valid = 1'b1; issue_rd = 3'd6;
        step();
        #1;
        check("sb_stall", issue_stall, 1'b1);
        step();
        idle(); wb_valid = 1'b1; rdvalalu = {16'h0606, 3'd6};
        step();
        // Same-edge commit and issue to R6: set wins
        wb_valid = 1'b1; rdvalalu = {16'h0607, 3'd6}; issue_valid = 1'b1; issue_rd = 3'd6;
        step();
        idle(); rs1_addr = 3'd6;
        #1;
        check("sb_set_wins", rs1_busy, 1'b1);
        step();

        // R0 commit
        wb_valid = 1'b1; wb_isld = 1'b1; rdvalmem = {16'hFFFF, 3'd0}; rs1_addr = 3'd0;
        step();
        idle();
        #1;
        check("r0_read", rs1_data, 16'h0);
        check("r0_done", wb_done, 1'b1);
        check("r0_last_data", wb_last_data, 16'hFFFF);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step();
        end

        // Fill the counter to 0xFFFF, then one more commit wraps it
        while (m_count != 16'hFFFF) begin
            rand_inputs();
            wb_valid = 1'b1;
            step();
        end
        check("pre_wrap", retired_count, 16'hFFFF);
        rand_inputs(); wb_valid = 1'b1;
        step();
        check("wrap", retired_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final stage of the 16-bit pipeline. Consumes the packed `{value, rd}` results from the memory stage (load path) and the ALU path, selects one per cycle, and commits it into an 8 x 16-bit register file. Provides two combinational read ports with same-cycle write bypass for decode, a per-register busy scoreboard for hazard stalls, and a retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 16, register/data width
- `NREG`, 8, number of architectural registers
- `REG_AW`, 3, register index width (log2 NREG)

Ports:
- `clk`  in  1  pipeline clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `wb_valid`  in  1  commit request this cycle
- `wb_isld`  in  1  1: take `rdvalmem`, 0: take `rdvalalu`
- `rdvalmem`  in  19  `{ldresult[15:0], rd[2:0]}` from memory stage
- `rdvalalu`  in  19  `{aluresult[15:0], rd[2:0]}` from ALU path
- `issue_valid`  in  1  decode issues an instruction writing `issue_rd`
- `issue_rd`  in  3  destination register of issuing instruction
- `issue_stall`  out  1  `issue_valid` and `busy[issue_rd]` (combinational)
- `rs1_addr`, `rs2_addr`  in  3 each  read port addresses
- `rs1_data`, `rs2_data`  out  16 each  read data (combinational)
- `rs1_busy`, `rs2_busy`  out  1 each  source has outstanding write
- `wb_done`  out  1  registered pulse, one cycle after a commit
- `wb_last_rd`  out  3  rd of last commit (registered)
- `wb_last_data`  out  16  data of last commit (registered)
- `retired_count`  out  16  commits since reset, wraps

## Operation
- Select: `sel = wb_isld ? rdvalmem : rdvalalu`; `wb_data = sel[18:3]`, `wb_rd = sel[2:0]`.
- Commit: on posedge with `wb_valid`, `regs[wb_rd] <= wb_data`, unless `wb_rd == 0`. R0 hardwired to 0; writes dropped, but the commit is still counted and still pulses `wb_done`.
- Scoreboard `busy[NREG-1:0]`:
  - Issue (`issue_valid && !issue_stall`, `issue_rd != 0`) sets `busy[issue_rd]`.
  - Commit clears `busy[wb_rd]`.
  - Same edge, same register, issue and commit: set wins (new producer outstanding).
  - `busy[0]` is always 0.
  - Commit to a non-busy register is legal and writes normally.
- Reads: `rsN_data = (rsN_addr == 0) ? 0 : regs[rsN_addr]`, plus bypass (see Configuration). `rsN_busy = busy[rsN_addr]`, forced 0 when bypass hits.
- `retired_count` increments by 1 per commit. Modulo 2^16: 0xFFFF -> 0x0000.
- `wb_last_rd` and `wb_last_data` hold the last committed values (including R0 commits) until the next commit.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-commit): all regs 0, busy 0, `retired_count` 0, `wb_done` 0, `wb_last_rd` 0, `wb_last_data` 0. `wb_valid` and `issue_valid` are ignored while `rst` is high.
- Write latency: data is visible in the array after the commit edge. With bypass it is visible on the read ports in the same cycle as `wb_valid`.
- `wb_done` is high for exactly the one cycle following each commit edge. Back-to-back commits hold it high continuously.
- `issue_stall`, read data, and busy flags are purely combinational from current state and inputs. No added cycle.
- Throughput: one commit per cycle, no backpressure on the commit path.

## Configuration
- `WB_BYPASS_EN` defined:
  - When `wb_valid`, `wb_rd == rsN_addr`, and `wb_rd != 0`: `rsN_data = wb_data` and `rsN_busy = 0` in that same cycle.
  - `issue_stall` also ignores a busy bit being cleared by a same-cycle commit to `issue_rd`.
- Not defined:
  - Reads return array contents only (old value) and busy stays 1 until the commit edge.
  - `issue_stall` uses the registered busy bits only.

## Test plan
- Reset: assert `rst` mid-cycle after writing R3=0x1234 -> R3 reads 0, `retired_count`=0, `wb_done`=0 immediately, without waiting for a clock edge.
- Load vs ALU select: `wb_isld=1`, `rdvalmem={0xBEEF,3'd5}`, `rdvalalu={0x1111,3'd2}` -> R5=0xBEEF, R2 unchanged, `wb_last_rd`=5, `wb_done` pulses one cycle.
- Bypass (`WB_BYPASS_EN`): `rs1_addr=4` during a commit of 0x00AA to R4 -> `rs1_data`=0x00AA and `rs1_busy`=0 in that cycle. Without the macro: old value returned and `rs1_busy`=1.
- Scoreboard: issue rd=6 -> `busy[6]`=1 and second issue to 6 gets `issue_stall`=1. Same-edge commit R6 and issue R6 -> `busy[6]` remains 1.
- R0: commit `{0xFFFF,3'd0}` -> R0 reads 0, `retired_count`+1, `wb_done` pulses, `wb_last_data`=0xFFFF.
- Counter wrap: preload by 65535 commits, one more commit -> `retired_count`=0x0000.
